// File: rtl/systolic_pkg.sv
// Shared constants, issue-FSM encoding and width helper for the systolic interpolator
// sequencer and its input FIFO.
package systolic_pkg;

    localparam int WORDLENGTH = 16;
    localparam int NPE        = 8;
    localparam int MINGAP     = 18;

    typedef enum logic {
        IDLE = 1'b0,
        GAP  = 1'b1
    } issue_state_t;

    // Bits needed to index 'value' entries (also the bits that hold value-1).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO: head word always visible from the register array, level count.
// Push is ignored when full and pop when empty; both together leave the level unchanged.
module sync_fifo #(
    parameter int WORDLENGTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      push_i,
    input  logic [WORDLENGTH-1:0]     push_dat_i,
    input  logic                      pop_i,
    output logic [WORDLENGTH-1:0]     head_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [$clog2(DEPTH):0]    level_o
);
    import systolic_pkg::*;

    localparam int AW   = clog2(DEPTH);
    localparam int LVLW = AW + 1;

    logic [WORDLENGTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LVLW-1:0]       level_q, level_d;
    logic                  do_push;
    logic                  do_pop;

    assign full_o  = (level_q == LVLW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            level_d = level_q + 1'b1;
        end else if (do_pop && !do_push) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: a word is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/systolic_sequencer.sv
// Feeds the systolic interpolator: buffers samples, issues spaced donext strobes, and
// qualifies the captured results once the PE chain has filled. Accepted word issues 2 cycles later.
module systolic_sequencer #(
    parameter int WORDLENGTH = systolic_pkg::WORDLENGTH,
    parameter int DEPTH      = 4,
    parameter int MINGAP     = systolic_pkg::MINGAP,
    parameter int FILL       = systolic_pkg::NPE
) (
    input  logic                      clk30x,
    input  logic                      reset,
    input  logic [WORDLENGTH-1:0]     in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [WORDLENGTH-1:0]     sys_inputword,
    output logic                      sys_donext,
    input  logic [WORDLENGTH-1:0]     sys_outputword,
    output logic [WORDLENGTH-1:0]     out_data,
    output logic                      out_valid,
    output logic [$clog2(DEPTH):0]    fifo_level
);
    import systolic_pkg::*;

    localparam int GAPW  = clog2(MINGAP);
    localparam int FILLW = clog2(FILL + 1);
    localparam logic [GAPW-1:0]  GAP_LOAD = GAPW'(MINGAP - 1);
    localparam logic [FILLW-1:0] FILL_MAX = FILLW'(FILL);

    issue_state_t          state_q, state_d;
    logic [GAPW-1:0]       gap_q, gap_d;
    logic [FILLW-1:0]      fill_q, fill_d;
    logic [WORDLENGTH-1:0] inword_q, inword_d;
    logic                  donext_q, donext_d;
    logic                  tag_q, tag_d;
    logic                  donext_d1_q;
    logic                  tag_d1_q;
    logic [WORDLENGTH-1:0] out_data_q;
    logic                  out_valid_q;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [WORDLENGTH-1:0] fifo_head;
    logic                  push;
    logic                  issue;

    // A pop in the same cycle does not open a full FIFO; ready depends on state only.
    assign in_ready = !fifo_full && !reset;
    assign push     = in_valid && in_ready;

    sync_fifo #(
        .WORDLENGTH (WORDLENGTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk_i      (clk30x),
        .reset_i    (reset),
        .push_i     (push),
        .push_dat_i (in_data),
        .pop_i      (issue),
        .head_o     (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .level_o    (fifo_level)
    );

    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        fill_d   = fill_q;
        inword_d = inword_q;
        donext_d = 1'b0;
        tag_d    = 1'b0;
        issue    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    issue    = 1'b1;
                    inword_d = fifo_head;
                    donext_d = 1'b1;
                    tag_d    = (fill_q == FILL_MAX);
                    gap_d    = GAP_LOAD;
                    state_d  = GAP;
                    if (fill_q != FILL_MAX) begin
                        fill_d = fill_q + 1'b1;
                    end
                end
            end
            GAP: begin
                // Leaving when the count reaches zero puts strobes exactly MINGAP apart.
                if (gap_q != '0) begin
                    gap_d = gap_q - 1'b1;
                end
                if (gap_q <= GAPW'(1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk30x) begin
        if (reset) begin
            state_q  <= IDLE;
            gap_q    <= '0;
            fill_q   <= '0;
            inword_q <= '0;
            donext_q <= 1'b0;
            tag_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            fill_q   <= fill_d;
            inword_q <= inword_d;
            donext_q <= donext_d;
            tag_q    <= tag_d;
        end
    end

    // The wrapper updates outputword at the end of the strobe cycle, so capture one cycle later.
    always_ff @(posedge clk30x) begin
        if (reset) begin
            donext_d1_q <= 1'b0;
            tag_d1_q    <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            donext_d1_q <= donext_q;
            tag_d1_q    <= tag_q;
            out_valid_q <= donext_d1_q && tag_d1_q;
            if (donext_d1_q) begin
                out_data_q <= sys_outputword;
            end
        end
    end

    assign sys_inputword = inword_q;
    assign sys_donext    = donext_q;
    assign out_data      = out_data_q;
    assign out_valid     = out_valid_q;

endmodule

// File: doc/systolic_sequencer.md
# systolic_sequencer

Upstream/downstream companion of the 8-tap systolic interpolator wrapper. Accepts non-uniform sample words through a valid/ready handshake and buffers them in a small FIFO. Issues single-cycle `donext` strobes with enforced minimum spacing, driving `inputword` alongside each strobe. Captures the wrapper's `outputword` after each strobe and presents it as a qualified output stream, suppressing results until the PE chain has filled.

## Interface
Parameters:
- `WORDLENGTH`, 16, sample/result word width
- `DEPTH`, 4, input FIFO depth (power of two, ≥2)
- `MINGAP`, 18, minimum clk30x cycles between `donext` pulses (≥2; 16 multiplier cycles + 2)
- `FILL`, 8, number of initial strobes whose results are discarded (PE chain length)

Ports:
- `clk30x` in 1: clock
- `reset` in 1: synchronous, active-high
- `in_data` in WORDLENGTH: sample word
- `in_valid` in 1: `in_data` valid
- `in_ready` out 1: word accepted when `in_valid && in_ready`
- `sys_inputword` out WORDLENGTH: to wrapper `inputword`
- `sys_donext` out 1: to wrapper `donext`; high exactly one cycle per issue
- `sys_outputword` in WORDLENGTH: from wrapper `outputword`
- `out_data` out WORDLENGTH: captured interpolated result
- `out_valid` out 1: one-cycle qualifier for `out_data`
- `fifo_level` out $clog2(DEPTH)+1: current FIFO occupancy

## Operation
- Reset values:
  - `sys_inputword=0`, `sys_donext=0`, `out_data=0`, `out_valid=0`, `fifo_level=0`.
  - `in_ready=0` while `reset` is high.
  - Gap counter = 0, fill counter = 0, capture pipeline cleared.
- `in_ready = !full && !reset` (combinational).
  - Push on `in_valid && in_ready`.
  - Push and pop in the same cycle: both occur and the level is unchanged.
  - When full, `in_ready` is low; a simultaneous pop does not open the handshake in that cycle.
- Issue state machine:
  - IDLE (`gapcnt==0`): if FIFO is non-empty, issue.
  - Issue edge: pop FIFO head into `sys_inputword`, set `sys_donext=1` (registered, one cycle), load `gapcnt=MINGAP-1`, go to GAP.
  - GAP: `sys_donext=0`; decrement `gapcnt` each cycle; at 0 return to IDLE.
  - Consequence: consecutive `sys_donext` pulses are ≥MINGAP cycles apart, exactly MINGAP when the FIFO stays non-empty.
  - `sys_inputword` holds its value between issues.
- Fill counter: increments on each issue, saturating at FILL.
- Capture:
  - `donext_d1` = `sys_donext` delayed one cycle.
  - On `donext_d1`, register `sys_outputword` into `out_data`.
  - Assert `out_valid` for one cycle if the fill count was already FILL when that strobe issued, i.e. the (FILL+1)th and later strobes.
- Arithmetic: no width growth. Counters sized from the parameters, with no wrap: the gap counter stops at 0 and the fill counter saturates.

## Timing
- Word accepted in cycle N (FIFO empty, IDLE) → `sys_donext=1` and `sys_inputword=word` in cycle N+2.
- Wrapper updates `outputword` at the end of the `donext` cycle. `out_valid`/`out_data` appear 2 cycles after the `sys_donext` cycle.
- Throughput: one word per MINGAP cycles.
- Reset mid-operation, at any cycle including a GAP or capture cycle:
  - FIFO flushed, strobe and pending capture cancelled, fill counter restarted.
  - The first post-reset issue occurs no earlier than cycle R+2 after the first accepted word.

## Structure
- Shared package `systolic_pkg`:
  - `WORDLENGTH`, `NPE=8` (= FILL), `MINGAP`.
  - State encoding IDLE/GAP.
  - `clog2` helper function.
- One sub-module: `sync_fifo` (parameterised WORDLENGTH/DEPTH, registered output, level count, synchronous active-high reset).
- Issue FSM, gap counter, fill counter and capture pipe live in the top level.

## Test plan
- Reset held 3 cycles, then released with no input → all outputs 0, `in_ready=1`, no `sys_donext` for 100 cycles.
- Single word 0x1234 accepted in cycle 10 → `sys_donext=1` only in cycle 12 with `sys_inputword=0x1234`, `fifo_level` back to 0, no `out_valid`.
- Back-to-back pushes of 0x0001..0x0006 → `sys_donext` exactly 18 cycles apart, `in_ready` low whenever `fifo_level==4`, words issued in order with none lost.
- Twelve words, wrapper model returning 0xA000+n after strobe n → `out_valid` only after strobes 9–12, each 2 cycles after its strobe, `out_data=0xA009..0xA00C`.
- Simultaneous push and pop at level 2 → level stays 2; push attempt at level 4 with a concurrent pop → word not accepted.
- Reset asserted 5 cycles into GAP with 3 words queued → level 0, no further strobe. After release, a new word 0x00FF is issued 2 cycles after acceptance and the fill counter restarts (its result is not flagged valid).
